seg7_scan_decoder: RTL and testbench
====================================

Name: seg7_scan_decoder

Overview:
- Monitors a time-multiplexed, active-high 7-segment display bus (segment lines plus one-hot digit strobes) and reconstructs the displayed digit values.
- Used as the checking/readback end of the segment-encoder path: on-chip loopback self-test and display-bus observation.
- Filters each strobe dwell for stability, decodes the pattern to BCD, and publishes a complete multi-digit frame atomically.

Parameters:
- NDIG, 4, number of multiplexed digits (number of dig_sel bits).
- STABLE, 3, extra consecutive identical samples required before capture; minimum 1.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- seg_in  in  8  segment bus {a,b,c,d,e,f,g,dp}, bit7=a … bit0=dp, active-high.
- dig_sel  in  NDIG  digit strobe, active-high, one-hot; bit i selects digit i.
- err_clr  in  1  one-cycle pulse that clears err_flags.
- digits_out  out  4*NDIG  digit i BCD code in bits [4i+3:4i]; value 4'hF for a dash.
- dp_out  out  NDIG  captured dp bit per digit.
- dash_out  out  NDIG  digit i showed a dash (pattern 0x02).
- frame_valid  out  1  one-cycle pulse when digits_out/dp_out/dash_out are updated.
- err_flags  out  2  sticky error flags: bit0 = unrecognised pattern; bit1 = multi-hot dig_sel.

Behaviour:
- Reset: all outputs are 0. The seen-mask, the shadow registers and the stability counter are cleared, and the FSM goes to IDLE. A reset mid-frame discards the partial frame.
- Decode table, segment bits 7:1 with dp masked:
  - 0=0xFC, 1=0x60, 2=0xDA, 3=0xF2, 4=0x66, 5=0xB6, 6=0xBE, 7=0xE0, 8=0xFE, 9=0xF6.
  - Dash 0x02 gives code 4'hF with dash=1.
  - Any other pattern is invalid.
- Sampling and stability:
  - {seg_in, dig_sel} is registered every cycle.
  - The counter resets to 0 when the new sample differs from the previous sample. Otherwise it increments, saturating at STABLE.
- FSM:
  - IDLE: dig_sel not one-hot (all-zero or multi-hot). Multi-hot sets err_flags[1]. The counter is held at 0.
  - SETTLE: one-hot sample is present and the counter is below STABLE.
  - CAPTURED: capture has been done for this dwell. The FSM stays here until the sample changes, then goes to SETTLE (if still one-hot) or IDLE.
- Capture:
  - Happens on the edge where the same sample has been taken STABLE+1 consecutive times. Example: with STABLE=3 and inputs constant from edge 0, capture occurs at edge 3.
  - At most one capture per dwell.
  - A valid pattern writes the shadow code/dp/dash for digit i and sets seen[i].
  - An invalid pattern sets err_flags[0]; the shadow register and seen mask are unchanged.
- Frame completion:
  - On the capture edge that makes seen all-ones, the shadow registers are copied to digits_out/dp_out/dash_out in the same edge, frame_valid is high for the next cycle only, and seen is cleared.
  - A digit recaptured before frame completion overwrites its shadow value (last value wins).
- Errors:
  - err_flags bits are sticky until err_clr.
  - If err_clr and a new error occur in the same cycle, the new error wins (the bit stays set).
- Outputs change only at frame completion or reset. They are never partially updated.

Decomposition:
- Package seg7_pkg:
  - segment-bit index constants (SEG_A..SEG_DP);
  - pattern constants SEG_0..SEG_9 and SEG_DASH (shared with the encoder side);
  - DASH_CODE = 4'hF.
- Sub-module seg7_pattern_decode: purely combinational, 7-bit pattern → {valid, dash, code[3:0]}. It is instanced once in the capture path.

Test Plan:
- Digits 1,2,3,4 on dig_sel 0001..1000, each held 6 cycles, STABLE=3:
  - seg values are 0x60, 0xDA, 0xF2, 0x66;
  - digits_out=16'h4321 and frame_valid is one cycle after the 4th capture edge;
  - err_flags=0.
- seg glitch pattern: present 0xB6 for 2 cycles, then switch to 0xF6 held 5 cycles on digit 0:
  - digit 0 captures 9 only, one capture for the dwell.
- Dash and dp: digit 2 = 0x03, others 0xFD:
  - dash_out=4'b0100; digits_out=16'h0F00;
  - dp_out=4'b1111 (0x03 and 0xFD both carry dp=1).
- Invalid pattern 0x80 held on digit 1:
  - err_flags[0]=1, no frame_valid;
  - err_clr pulse together with a fresh 0x80 capture leaves err_flags[0]=1.
- dig_sel=0011 held 5 cycles:
  - err_flags[1]=1, no capture;
  - dig_sel=0000 raises no error.
- Reset asserted after 3 of 4 digits captured, then a full frame 5,6,7,8:
  - first frame_valid carries 16'h8765, not stale data.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment bit positions, digit patterns, decode types.
// Pattern constants are full 8-bit bus values with dp cleared; bits 7:1 carry a..g.
// Used by both the encoder side and the scan decoder so the tables cannot drift apart.
package seg7_pkg;

  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  localparam logic [7:0] SEG_0    = 8'hFC;
  localparam logic [7:0] SEG_1    = 8'h60;
  localparam logic [7:0] SEG_2    = 8'hDA;
  localparam logic [7:0] SEG_3    = 8'hF2;
  localparam logic [7:0] SEG_4    = 8'h66;
  localparam logic [7:0] SEG_5    = 8'hB6;
  localparam logic [7:0] SEG_6    = 8'hBE;
  localparam logic [7:0] SEG_7    = 8'hE0;
  localparam logic [7:0] SEG_8    = 8'hFE;
  localparam logic [7:0] SEG_9    = 8'hF6;
  localparam logic [7:0] SEG_DASH = 8'h02;

  localparam logic [3:0] DASH_CODE = 4'hF;

  // Result of decoding one segment pattern.
  typedef struct packed {
    logic       valid;
    logic       dash;
    logic [3:0] code;
  } dec_t;

  // Per-dwell capture state of the scan decoder.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURED
  } state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational 7-bit segment pattern (a..g, dp excluded) to BCD/dash decode.
// Latency: zero cycles, purely combinational.
// No flow control; unknown patterns return valid=0.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pat,
  output dec_t       dec
);

  // Table lookup; anything not in the table is flagged invalid.
  always_comb begin
    dec = '0;
    dec.valid = 1'b1;
    case (pat)
      SEG_0[7:1]:    dec.code = 4'd0;
      SEG_1[7:1]:    dec.code = 4'd1;
      SEG_2[7:1]:    dec.code = 4'd2;
      SEG_3[7:1]:    dec.code = 4'd3;
      SEG_4[7:1]:    dec.code = 4'd4;
      SEG_5[7:1]:    dec.code = 4'd5;
      SEG_6[7:1]:    dec.code = 4'd6;
      SEG_7[7:1]:    dec.code = 4'd7;
      SEG_8[7:1]:    dec.code = 4'd8;
      SEG_9[7:1]:    dec.code = 4'd9;
      SEG_DASH[7:1]: begin
        dec.code = DASH_CODE;
        dec.dash = 1'b1;
      end
      default:       dec.valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Reconstructs digits from a multiplexed 7-seg bus; publishes whole frames atomically.
// Latency: capture on the (STABLE+1)th identical sample; frame_valid one cycle after the completing capture.
// No backpressure: the display bus free-runs, frames are presented as a one-cycle pulse.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NDIG   = 4,
  parameter int STABLE = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        seg_in,
  input  logic [NDIG-1:0]   dig_sel,
  input  logic              err_clr,
  output logic [4*NDIG-1:0] digits_out,
  output logic [NDIG-1:0]   dp_out,
  output logic [NDIG-1:0]   dash_out,
  output logic              frame_valid,
  output logic [1:0]        err_flags
);

  localparam int             CW      = $clog2(STABLE + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE);

  logic [7:0]        samp_seg;
  logic [NDIG-1:0]   samp_dig;
  logic [CW-1:0]     cnt, cnt_nxt;
  state_t            state, state_nxt;
  logic              same, onehot, multihot, cap, cap_ok, frame_done;
  logic [1:0]        err_new;
  dec_t              dec;

  logic [NDIG-1:0]   seen, seen_nxt;
  logic [4*NDIG-1:0] sh_code, sh_code_nxt;
  logic [NDIG-1:0]   sh_dp, sh_dp_nxt;
  logic [NDIG-1:0]   sh_dash, sh_dash_nxt;

  // Decoding the live bus is equivalent to decoding the stored sample on a capture
  // edge, since capture only happens when the two are identical.
  seg7_pattern_decode u_dec (
    .pat (seg_in[7:1]),
    .dec (dec)
  );

  // Stability counter and dwell FSM: capture once per stable one-hot dwell.
  always_comb begin
    same      = ({seg_in, dig_sel} == {samp_seg, samp_dig});
    onehot    = $onehot(dig_sel);
    multihot  = !onehot && (dig_sel != '0);
    state_nxt = state;
    cnt_nxt   = '0;
    cap       = 1'b0;
    if (!onehot) begin
      state_nxt = ST_IDLE;
    end else if (!same) begin
      state_nxt = ST_SETTLE;
    end else begin
      cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
      if (state == ST_CAPTURED) begin
        state_nxt = ST_CAPTURED;
      end else if (cnt_nxt == CNT_MAX) begin
        cap       = 1'b1;
        state_nxt = ST_CAPTURED;
      end else begin
        state_nxt = ST_SETTLE;
      end
    end
  end

  // Shadow update, seen-mask tracking and frame completion detect.
  always_comb begin
    cap_ok      = cap && dec.valid;
    err_new     = {multihot, cap && !dec.valid};
    seen_nxt    = seen;
    sh_code_nxt = sh_code;
    sh_dp_nxt   = sh_dp;
    sh_dash_nxt = sh_dash;
    if (cap_ok) begin
      for (int i = 0; i < NDIG; i++) begin
        if (dig_sel[i]) begin
          sh_code_nxt[4*i +: 4] = dec.code;
          sh_dp_nxt[i]          = seg_in[SEG_DP];
          sh_dash_nxt[i]        = dec.dash;
          seen_nxt[i]           = 1'b1;
        end
      end
    end
    frame_done = cap_ok && (&seen_nxt);
    if (frame_done) begin
      seen_nxt = '0;
    end
  end

  // Sample register, counter, FSM state and shadow/seen state.
  always_ff @(posedge clk) begin
    if (rst) begin
      samp_seg <= '0;
      samp_dig <= '0;
      cnt      <= '0;
      state    <= ST_IDLE;
      seen     <= '0;
      sh_code  <= '0;
      sh_dp    <= '0;
      sh_dash  <= '0;
    end else begin
      samp_seg <= seg_in;
      samp_dig <= dig_sel;
      cnt      <= cnt_nxt;
      state    <= state_nxt;
      seen     <= seen_nxt;
      sh_code  <= sh_code_nxt;
      sh_dp    <= sh_dp_nxt;
      sh_dash  <= sh_dash_nxt;
    end
  end

  // Published frame, frame pulse and sticky errors (a new error beats err_clr).
  always_ff @(posedge clk) begin
    if (rst) begin
      digits_out  <= '0;
      dp_out      <= '0;
      dash_out    <= '0;
      frame_valid <= 1'b0;
      err_flags   <= '0;
    end else begin
      frame_valid <= frame_done;
      err_flags   <= (err_flags & ~{2{err_clr}}) | err_new;
      if (frame_done) begin
        digits_out <= sh_code_nxt;
        dp_out     <= sh_dp_nxt;
        dash_out   <= sh_dash_nxt;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder (NDIG=4, STABLE=3).
// Expected frames are queued when the completing digit is driven, checked on frame_valid.
// Error flags and reset state are checked directly at fixed points in the sequence.
module tb_seg7_scan_decoder;

  localparam int STABLE = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  seg_in;
  logic [3:0]  dig_sel;
  logic        err_clr;
  logic [15:0] digits_out;
  logic [3:0]  dp_out;
  logic [3:0]  dash_out;
  logic        frame_valid;
  logic [1:0]  err_flags;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  dp;
    logic [3:0]  da;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  seg7_scan_decoder #(.NDIG(4), .STABLE(STABLE)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .dig_sel     (dig_sel),
    .err_clr     (err_clr),
    .digits_out  (digits_out),
    .dp_out      (dp_out),
    .dash_out    (dash_out),
    .frame_valid (frame_valid),
    .err_flags   (err_flags)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Drive one dwell of n cycles; optionally queue the frame this dwell completes.
  // Capture falls on the (STABLE+1)th rising edge of the dwell.
  task automatic hold(input logic [7:0] s, input logic [3:0] d, input int n,
                      input bit push = 1'b0, input logic [15:0] ed = '0,
                      input logic [3:0] edp = '0, input logic [3:0] eda = '0);
    exp_t e;
    @(negedge clk);
    seg_in  = s;
    dig_sel = d;
    if (push) begin
      e.d   = ed;
      e.dp  = edp;
      e.da  = eda;
      e.cyc = cyc + 1 + STABLE;
      sb.push_back(e);
    end
    repeat (n) @(posedge clk);
  endtask

  task automatic clr_pulse();
    @(negedge clk);
    seg_in  = 8'h00;
    dig_sel = 4'b0000;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  // Frame monitor: every frame_valid must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && frame_valid) begin
      chk("frame_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk("digits_out", 32'(digits_out), 32'(mon_e.d));
        chk("dp_out",     32'(dp_out),     32'(mon_e.dp));
        chk("dash_out",   32'(dash_out),   32'(mon_e.da));
        chk("frame_cycle", 32'(cyc),       32'(mon_e.cyc));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    seg_in  = 8'h00;
    dig_sel = 4'b0000;
    err_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_digits", 32'(digits_out), 32'h0);
    chk("rst_dp",     32'(dp_out),     32'h0);
    chk("rst_dash",   32'(dash_out),   32'h0);
    chk("rst_fv",     32'(frame_valid), 32'h0);
    chk("rst_err",    32'(err_flags),  32'h0);
    rst = 1'b0;

    // Basic frame 1,2,3,4.
    hold(8'h60, 4'b0001, 6);
    hold(8'hDA, 4'b0010, 6);
    hold(8'hF2, 4'b0100, 6);
    hold(8'h66, 4'b1000, 6, 1'b1, 16'h4321, 4'h0, 4'h0);
    hold(8'h00, 4'b0000, 2);
    chk("err_after_frame1", 32'(err_flags), 32'h0);

    // Glitch on digit 0: short 5 must not be captured, 9 wins.
    hold(8'hB6, 4'b0001, 2);
    hold(8'hF6, 4'b0001, 5);
    hold(8'h60, 4'b0010, 6);
    hold(8'hDA, 4'b0100, 6);
    hold(8'hF2, 4'b1000, 6, 1'b1, 16'h3219, 4'h0, 4'h0);

    // Dash with dp on digit 2, zeros with dp elsewhere.
    hold(8'hFD, 4'b0001, 6);
    hold(8'hFD, 4'b0010, 6);
    hold(8'h03, 4'b0100, 6);
    hold(8'hFD, 4'b1000, 6, 1'b1, 16'h0F00, 4'hF, 4'h4);
    hold(8'h00, 4'b0000, 2);

    // Invalid pattern sets err_flags[0] and produces no frame.
    hold(8'h80, 4'b0010, 6);
    chk("err_invalid", 32'(err_flags), 32'h1);
    hold(8'h00, 4'b0000, 2);
    // err_clr coinciding with a fresh invalid capture: the error stays.
    @(negedge clk);
    seg_in  = 8'h80;
    dig_sel = 4'b0010;
    repeat (3) @(posedge clk);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr_vs_new", 32'(err_flags), 32'h1);
    clr_pulse();
    chk("err_cleared", 32'(err_flags), 32'h0);

    // Multi-hot strobe flags err_flags[1]; all-zero strobe does not.
    hold(8'h60, 4'b0011, 5);
    chk("err_multihot", 32'(err_flags), 32'h2);
    clr_pulse();
    hold(8'h60, 4'b0000, 5);
    chk("err_zero_sel", 32'(err_flags), 32'h0);

    // Reset after three captured digits must discard the partial frame.
    hold(8'h60, 4'b0001, 6);
    hold(8'hDA, 4'b0010, 6);
    hold(8'hF2, 4'b0100, 6);
    @(negedge clk);
    rst     = 1'b1;
    seg_in  = 8'h00;
    dig_sel = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midrst_digits", 32'(digits_out), 32'h0);
    chk("midrst_dp",     32'(dp_out),     32'h0);
    chk("midrst_dash",   32'(dash_out),   32'h0);
    rst = 1'b0;
    hold(8'hFE, 4'b1000, 6);
    hold(8'hE0, 4'b0100, 6);
    hold(8'hBE, 4'b0010, 6);
    hold(8'hB6, 4'b0001, 6, 1'b1, 16'h8765, 4'h0, 4'h0);
    hold(8'h00, 4'b0000, 3);

    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
